// File: rtl/mmio_pkg.sv
// mmio_pkg: shared types and constants for the memory-mapped I/O hub.
// Holds the hub state encoding, the read data returned on a failed access,
// and the default peripheral base addresses used when the top is built.
package mmio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2,
        ST_ERR    = 2'd3
    } mmio_state_t;

    // Read data handed back to the CPU whenever an access ends in error
    localparam logic [31:0] MMIO_ERR_RDATA = 32'hDEAD_BEEF;

    // Default peripheral windows (64 KiB each with the default mask)
    localparam logic [31:0] DRAM_BASE = 32'h1001_0000;
    localparam logic [31:0] SEG7_BASE = 32'h1002_0000;
    localparam logic [31:0] SW_BASE   = 32'h1003_0000;
    localparam logic [31:0] KB_BASE   = 32'h1004_0000;

endpackage

// File: rtl/mmio_decode.sv
// mmio_decode: combinational base/mask address decoder.
// Channel i matches when (addr & mask_i) == base_i; when several channels
// match, the lowest index is reported.
module mmio_decode #(
    parameter int                   N_CH    = 4,
    parameter int                   AW      = 32,
    parameter logic [N_CH*AW-1:0]   CH_BASE = {N_CH{32'h0}},
    parameter logic [N_CH*AW-1:0]   CH_MASK = {N_CH{32'hFFFF_0000}},
    localparam int                  IW      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic [AW-1:0] addr,
    output logic          hit,
    output logic [IW-1:0] idx
);

    // Scan from the highest channel down so the lowest matching index is left last
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if ((addr & CH_MASK[i*AW +: AW]) == CH_BASE[i*AW +: AW]) begin
                hit = 1'b1;
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/mmio_hub.sv
// mmio_hub: CPU data port to N peripheral channels with base/mask decode,
// ready/stall handshake and sticky error capture.
// Optional feature: define MMIO_TIMEOUT_EN to abort an ACCESS that has not
// seen ready after TIMEOUT+1 cycles; without it ACCESS waits indefinitely.
module mmio_hub
    import mmio_pkg::*;
#(
    parameter int                   N_CH    = 4,
    parameter int                   DW      = 32,
    parameter int                   AW      = 32,
    parameter logic [N_CH*AW-1:0]   CH_BASE = {N_CH{32'h0}},
    parameter logic [N_CH*AW-1:0]   CH_MASK = {N_CH{32'hFFFF_0000}},
    parameter int                   TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_cs,
    input  logic                 cpu_we,
    input  logic [AW-1:0]        cpu_addr,
    input  logic [DW-1:0]        cpu_wdata,
    output logic [DW-1:0]        cpu_rdata,
    output logic                 cpu_stall,
    output logic [N_CH-1:0]      per_cs,
    output logic                 per_we,
    output logic [AW-1:0]        per_addr,
    output logic [DW-1:0]        per_wdata,
    input  logic [N_CH*DW-1:0]   per_rdata,
    input  logic [N_CH-1:0]      per_ready,
    output logic                 err_flag,
    output logic [AW-1:0]        err_addr,
    input  logic                 err_clr
);

    localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;

    mmio_state_t     r_state;
    logic [IW-1:0]   r_idx;
    logic            r_we;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [DW-1:0]   r_rdata;
    logic            r_err_flag;
    logic [AW-1:0]   r_err_addr;

    logic            w_hit;
    logic [IW-1:0]   w_idx;
    logic            w_sel_ready;
    logic [DW-1:0]   w_sel_rdata;
    logic            w_timeout;
    logic            w_err_evt;
    logic [AW-1:0]   w_err_addr;

    mmio_decode #(
        .N_CH    (N_CH),
        .AW      (AW),
        .CH_BASE (CH_BASE),
        .CH_MASK (CH_MASK)
    ) u_decode (
        .addr (cpu_addr),
        .hit  (w_hit),
        .idx  (w_idx)
    );

    // Only the latched channel's ready and read data are ever looked at
    assign w_sel_ready = per_ready[r_idx];
    assign w_sel_rdata = per_rdata[r_idx*DW +: DW];

`ifdef MMIO_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] r_tocnt;

    // Cycle counter for the current ACCESS; held at zero outside it so every access starts fresh
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tocnt <= '0;
        end else if (r_state == ST_ACCESS) begin
            r_tocnt <= r_tocnt + 1'b1;
        end else begin
            r_tocnt <= '0;
        end
    end

    assign w_timeout = (r_tocnt == TO_W'(TIMEOUT));
`else
    assign w_timeout = 1'b0;
`endif

    // Main handshake FSM: latch the request, wait for the channel, then release the CPU
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cpu_cs) begin
                        r_addr  <= cpu_addr;
                        r_wdata <= cpu_wdata;
                        r_we    <= cpu_we;
                        r_idx   <= w_idx;
                        if (w_hit) begin
                            r_state <= ST_ACCESS;
                        end else begin
                            r_state <= ST_ERR;
                            r_rdata <= DW'(MMIO_ERR_RDATA);
                        end
                    end
                end
                ST_ACCESS: begin
                    if (w_sel_ready) begin
                        if (!r_we) begin
                            r_rdata <= w_sel_rdata;
                        end
                        r_state <= ST_DONE;
                    end else if (w_timeout) begin
                        r_state <= ST_ERR;
                        r_rdata <= DW'(MMIO_ERR_RDATA);
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                ST_ERR:  r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // An error is either an unmapped request in IDLE or an expired wait in ACCESS
    assign w_err_evt  = ((r_state == ST_IDLE) && cpu_cs && !w_hit) ||
                        ((r_state == ST_ACCESS) && !w_sel_ready && w_timeout);
    assign w_err_addr = (r_state == ST_IDLE) ? cpu_addr : r_addr;

    // Sticky error capture: keep the first address, but a new error outranks a same-cycle clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err_flag <= 1'b0;
            r_err_addr <= '0;
        end else if (w_err_evt) begin
            r_err_flag <= 1'b1;
            if (!r_err_flag || err_clr) begin
                r_err_addr <= w_err_addr;
            end
        end else if (err_clr) begin
            r_err_flag <= 1'b0;
            r_err_addr <= '0;
        end
    end

    assign cpu_stall = ((r_state == ST_IDLE) && cpu_cs) || (r_state == ST_ACCESS);
    assign per_cs    = (r_state == ST_ACCESS) ? (N_CH'(1) << r_idx) : '0;
    assign per_we    = (r_state == ST_ACCESS) && r_we;
    assign per_addr  = r_addr;
    assign per_wdata = r_wdata;
    assign cpu_rdata = r_rdata;
    assign err_flag  = r_err_flag;
    assign err_addr  = r_err_addr;

endmodule

// File: tb/tb_mmio_hub.sv
// tb_mmio_hub: directed self-checking bench for mmio_hub.
// Honours MMIO_TIMEOUT_EN: with it the hung-access case expects an error
// after TIMEOUT+1 ACCESS cycles, without it the stall must persist.
module tb_mmio_hub;

    localparam int N_CH    = 4;
    localparam int DW      = 32;
    localparam int AW      = 32;
    localparam int TIMEOUT = 15;
    localparam logic [N_CH*AW-1:0] BASES = {32'h1003_0000, 32'h1002_0000, 32'h1001_0000, 32'h1001_0000};
    localparam logic [N_CH*AW-1:0] MASKS = {32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_FFFF};

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 cpu_cs = 1'b0;
    logic                 cpu_we = 1'b0;
    logic [AW-1:0]        cpu_addr = '0;
    logic [DW-1:0]        cpu_wdata = '0;
    logic [DW-1:0]        cpu_rdata;
    logic                 cpu_stall;
    logic [N_CH-1:0]      per_cs;
    logic                 per_we;
    logic [AW-1:0]        per_addr;
    logic [DW-1:0]        per_wdata;
    logic [N_CH*DW-1:0]   per_rdata = '0;
    logic [N_CH-1:0]      per_ready = '0;
    logic                 err_flag;
    logic [AW-1:0]        err_addr;
    logic                 err_clr = 1'b0;

    int compared   = 0;
    int mismatched = 0;

    int              stalls;
    logic [N_CH-1:0] csSeen;
    logic            weSeen;
    logic [DW-1:0]   wdataSeen;
    logic [AW-1:0]   addrSeen;

    mmio_hub #(
        .N_CH    (N_CH),
        .DW      (DW),
        .AW      (AW),
        .CH_BASE (BASES),
        .CH_MASK (MASKS),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_cs    (cpu_cs),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .per_cs    (per_cs),
        .per_we    (per_we),
        .per_addr  (per_addr),
        .per_wdata (per_wdata),
        .per_rdata (per_rdata),
        .per_ready (per_ready),
        .err_flag  (err_flag),
        .err_addr  (err_addr),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Hold a request until stall drops or the cycle budget runs out.
    // Cycle n=0 is the IDLE request cycle; the target channel's ready is
    // raised from cycle readyFrom on, while every other channel's ready is
    // held high throughout to show that it is ignored.
    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                 input int ch, input int readyFrom, input logic [31:0] rdVal,
                                 input int budget);
        logic [N_CH-1:0] chBit;
        chBit     = N_CH'(1) << ch;
        stalls    = 0;
        csSeen    = '0;
        weSeen    = 1'b0;
        wdataSeen = '0;
        addrSeen  = '0;
        per_rdata = {N_CH{32'h0BAD_0BAD}};
        per_rdata[ch*DW +: DW] = rdVal;
        cpu_cs    = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        for (int n = 0; n < budget; n++) begin
            per_ready = ~chBit | ((n >= readyFrom) ? chBit : '0);
            #1;
            if (!cpu_stall) break;
            stalls++;
            if (n == 1) begin
                csSeen    = per_cs;
                weSeen    = per_we;
                wdataSeen = per_wdata;
                addrSeen  = per_addr;
            end
            tick();
        end
    endtask

    task automatic endRequest();
        cpu_cs    = 1'b0;
        cpu_we    = 1'b0;
        per_ready = '0;
        tick();
    endtask

    initial begin
        // Reset values
        tick();
        tick();
        checkOutput("rst_per_cs",    32'(per_cs),    32'h0);
        checkOutput("rst_per_we",    32'(per_we),    32'h0);
        checkOutput("rst_per_addr",  per_addr,       32'h0);
        checkOutput("rst_per_wdata", per_wdata,      32'h0);
        checkOutput("rst_cpu_rdata", cpu_rdata,      32'h0);
        checkOutput("rst_err_flag",  32'(err_flag),  32'h0);
        checkOutput("rst_err_addr",  err_addr,       32'h0);
        checkOutput("rst_stall",     32'(cpu_stall), 32'h0);
        rst = 1'b1;
        tick();

        // Read ch1 with ready on the third ACCESS cycle
        applyStimulus(1'b0, 32'h1001_0004, 32'h0, 1, 3, 32'h1234_5678, 50);
        checkOutput("rd_stalls", 32'(stalls),  32'd4);
        checkOutput("rd_cs",     32'(csSeen),  32'h2);
        checkOutput("rd_we",     32'(weSeen),  32'h0);
        checkOutput("rd_addr",   addrSeen,     32'h1001_0004);
        checkOutput("rd_rdata",  cpu_rdata,    32'h1234_5678);
        checkOutput("rd_done_cs", 32'(per_cs), 32'h0);
        endRequest();

        // Write ch2 with ready already high: minimum latency, rdata untouched
        applyStimulus(1'b1, 32'h1002_0008, 32'hA5A5_A5A5, 2, 0, 32'h5555_5555, 50);
        checkOutput("wr_stalls", 32'(stalls), 32'd2);
        checkOutput("wr_cs",     32'(csSeen), 32'h4);
        checkOutput("wr_we",     32'(weSeen), 32'h1);
        checkOutput("wr_wdata",  wdataSeen,   32'hA5A5_A5A5);
        checkOutput("wr_rdata",  cpu_rdata,   32'h1234_5678);
        endRequest();

        // Unmapped read: one stall cycle, then the error response
        applyStimulus(1'b0, 32'h2000_0000, 32'h0, 0, 0, 32'h0, 50);
        checkOutput("um1_stalls", 32'(stalls),   32'd1);
        checkOutput("um1_rdata",  cpu_rdata,     32'hDEAD_BEEF);
        checkOutput("um1_flag",   32'(err_flag), 32'h1);
        checkOutput("um1_addr",   err_addr,      32'h2000_0000);
        checkOutput("um1_cs",     32'(per_cs),   32'h0);
        endRequest();

        // Second unmapped access keeps the first error address
        applyStimulus(1'b0, 32'h3000_0000, 32'h0, 0, 0, 32'h0, 50);
        checkOutput("um2_stalls", 32'(stalls),   32'd1);
        checkOutput("um2_flag",   32'(err_flag), 32'h1);
        checkOutput("um2_addr",   err_addr,      32'h2000_0000);
        endRequest();

        // Clear
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        #1;
        checkOutput("clr_flag", 32'(err_flag), 32'h0);
        checkOutput("clr_addr", err_addr,      32'h0);

        // Error and clear in the same cycle: the error wins and reloads the address
        applyStimulus(1'b0, 32'h2000_0000, 32'h0, 0, 0, 32'h0, 50);
        endRequest();
        cpu_cs   = 1'b1;
        cpu_addr = 32'h4000_0000;
        err_clr  = 1'b1;
        #1;
        checkOutput("ec_stall", 32'(cpu_stall), 32'h1);
        tick();
        err_clr = 1'b0;
        #1;
        checkOutput("ec_flag", 32'(err_flag), 32'h1);
        checkOutput("ec_addr", err_addr,      32'h4000_0000);
        endRequest();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // Overlapping windows: ch0 and ch1 both decode 0x1001_0000, ch0 wins
        applyStimulus(1'b0, 32'h1001_0000, 32'h0, 0, 0, 32'h0000_C0DE, 50);
        checkOutput("pri_cs",     32'(csSeen), 32'h1);
        checkOutput("pri_stalls", 32'(stalls), 32'd2);
        checkOutput("pri_rdata",  cpu_rdata,   32'h0000_C0DE);
        endRequest();

`ifdef MMIO_TIMEOUT_EN
        // Hung channel aborts after TIMEOUT+1 ACCESS cycles
        applyStimulus(1'b0, 32'h1003_0000, 32'h0, 3, 100000, 32'h0, 100);
        checkOutput("to_stalls", 32'(stalls),   32'(TIMEOUT + 2));
        checkOutput("to_flag",   32'(err_flag), 32'h1);
        checkOutput("to_addr",   err_addr,      32'h1003_0000);
        checkOutput("to_rdata",  cpu_rdata,     32'hDEAD_BEEF);
        endRequest();
        applyStimulus(1'b0, 32'h1003_0000, 32'h0, 3, 100000, 32'h0, 5);
        checkOutput("hang_stalls", 32'(stalls), 32'd5);
`else
        // Hung channel keeps the CPU stalled indefinitely
        applyStimulus(1'b0, 32'h1003_0000, 32'h0, 3, 100000, 32'h0, 1000);
        checkOutput("hang_stalls", 32'(stalls),   32'd1000);
        checkOutput("hang_cs",     32'(per_cs),   32'h8);
        checkOutput("hang_flag",   32'(err_flag), 32'h0);
`endif

        // Reset in the middle of ACCESS drops the select at once
        rst       = 1'b0;
        cpu_cs    = 1'b0;
        per_ready = '0;
        #1;
        checkOutput("mid_rst_cs",    32'(per_cs),    32'h0);
        checkOutput("mid_rst_stall", 32'(cpu_stall), 32'h0);
        checkOutput("mid_rst_flag",  32'(err_flag),  32'h0);
        checkOutput("mid_rst_rdata", cpu_rdata,      32'h0);
        tick();
        rst = 1'b1;
        tick();

        // Normal read after reset release
        applyStimulus(1'b0, 32'h1001_0010, 32'h0, 1, 2, 32'hCAFE_F00D, 50);
        checkOutput("post_stalls", 32'(stalls), 32'd3);
        checkOutput("post_cs",     32'(csSeen), 32'h2);
        checkOutput("post_rdata",  cpu_rdata,   32'hCAFE_F00D);
        endRequest();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mmio_hub.md
# mmio_hub

Parametrised memory-mapped I/O hub between the CPU data port and N peripheral channels (data RAM, seg7, switches, keyboard, future devices). It replaces fixed single-cycle chip-select decoding with per-channel base/mask decode, a ready/stall handshake so slow peripherals can hold the CPU, and error capture for unmapped or hung accesses. It sits between `CPU` and the peripherals in the top-level dataflow.

## Interface
- `N_CH`, 4: number of peripheral channels.
- `DW`, 32: data width.
- `AW`, 32: address width.
- `CH_BASE`, {N_CH{32'h0}}: packed base addresses; channel i occupies `[i*AW +: AW]`.
- `CH_MASK`, {N_CH{32'hFFFF_0000}}: packed decode masks.
- `TIMEOUT`, 255: maximum wait cycles in ACCESS; `TO_W = $clog2(TIMEOUT+1)`.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-low reset.
- `cpu_cs` in 1: access request (CPU `DM_CS`).
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in AW: byte address.
- `cpu_wdata` in DW: write data.
- `cpu_rdata` out DW: registered read data.
- `cpu_stall` out 1: CPU must hold PC and request stable while high.
- `per_cs` out N_CH: one-hot channel select.
- `per_we` out 1: write strobe, shared.
- `per_addr` out AW: latched address, shared.
- `per_wdata` out DW: latched write data, shared.
- `per_rdata` in N_CH*DW: packed channel read data.
- `per_ready` in N_CH: per-channel completion.
- `err_flag` out 1: sticky error.
- `err_addr` out AW: address of the first error since clear.
- `err_clr` in 1: clears `err_flag`/`err_addr`.

## Operation
- States: IDLE, ACCESS, DONE, ERR.
- Decode: channel i hits when `(cpu_addr & MASK_i) == BASE_i`. With multiple hits, the lowest index wins.
- IDLE: if `cpu_cs` is high, latch addr/wdata/we and the decoded index.
  - Hit → ACCESS.
  - No hit → ERR.
- ACCESS: `per_cs[idx]=1`, `per_we` = latched we.
  - On `per_ready[idx]`: capture `per_rdata[idx]` into `cpu_rdata` (reads only), → DONE.
- DONE and ERR: `per_cs=0`, stall low for exactly one cycle, then → IDLE.
- ERR: `cpu_rdata = 32'hDEAD_BEEF`, `err_flag=1`.
  - `err_addr` is loaded only if `err_flag` was 0, so the first error is kept.
- `cpu_stall = (state==IDLE && cpu_cs) || state==ACCESS`. This is combinational.
- A write never alters `cpu_rdata`.
- `err_clr` in the same cycle as a new error: the error wins (flag stays 1, addr reloaded).

## Timing
- Reset values: state IDLE, `per_cs=0`, `per_we=0`, `per_addr=0`, `per_wdata=0`, `cpu_rdata=0`, `err_flag=0`, `err_addr=0`, timeout counter 0.
- Minimum latency: 2 stall cycles (IDLE request, ACCESS with `per_ready` already high), followed by the DONE cycle in which the CPU advances.
- A peripheral ready after k ACCESS cycles gives k+1 stall cycles.
- Unmapped access: 1 stall cycle, then ERR.
- Back-to-back requests: DONE/ERR → IDLE, and the new request is accepted the following cycle.
- `per_ready` is sampled only for the selected channel. Ready on other channels is ignored.
- Reset asserted mid-ACCESS drops `per_cs` immediately (asynchronous reset), with no completion.

## Configuration
- `MMIO_TIMEOUT_EN` defined: the counter increments in ACCESS and clears on entry.
  - When the counter reaches `TIMEOUT` without ready → ERR, so there are TIMEOUT+1 ACCESS cycles.
- `MMIO_TIMEOUT_EN` undefined: no counter logic. ACCESS waits indefinitely, and ERR is reached only via unmapped decode.

## Structure
- `mmio_pkg` holds:
  - the state enum `mmio_state_t`;
  - `MMIO_ERR_RDATA = 32'hDEAD_BEEF`;
  - the default base constants `SEG7_BASE`, `SW_BASE`, `KB_BASE`, `DRAM_BASE = 32'h1001_0000`.
- Sub-module `mmio_decode` is a combinational priority decoder. It takes the address, `CH_BASE` and `CH_MASK`, and outputs `hit` and `idx[$clog2(N_CH)-1:0]`.

## Test plan
- Read ch1 (base 0x1001_0000, mask 0xFFFF_0000) at 0x1001_0004, with `per_ready[1]` after 3 ACCESS cycles and rdata 0x1234_5678 → `per_cs=4'b0010`, 4 stall cycles, `cpu_rdata=0x1234_5678` in DONE.
- Write 0xA5A5_A5A5 to ch2 with ready tied high → `per_we=1`, `per_wdata=0xA5A5_A5A5`, exactly 2 stall cycles, `cpu_rdata` unchanged.
- Access 0x2000_0000 (unmapped) → 1 stall cycle, `cpu_rdata=0xDEAD_BEEF`, `err_flag=1`, `err_addr=0x2000_0000`. A second unmapped access at 0x3000_0000 leaves `err_addr` unchanged. `err_clr` → both cleared.
- `MMIO_TIMEOUT_EN` with TIMEOUT=15 and ready never asserted → ERR after 16 ACCESS cycles, `err_flag=1`. Without the macro, stall stays high for 1000 cycles.
- ch0 and ch1 both matching 0x1001_0000 → only `per_cs[0]` asserted.
- `rst` pulled low during ACCESS → `per_cs=0` and `cpu_stall=0` immediately. After release, state is IDLE and a new read completes normally.
